// File: rtl/prog_mem_loader_if.sv
// Loader byte-stream and CPU instruction-fetch signals for prog_mem_loader.
// master = loader/CPU side, slave = program memory.
interface prog_mem_loader_if;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic [15:0] address;
  logic [15:0] data_out;

  modport master (
    output load_valid, load_data, load_last, address,
    input  load_ready, data_out
  );

  modport slave (
    input  load_valid, load_data, load_last, address,
    output load_ready, data_out
  );
endinterface

// File: rtl/prog_mem_loader.sv
// Program memory filled from a big-endian byte stream, then served to the CPU fetch port.
// Optional PROG_MEM_RELOAD_EN adds a reload input that returns RUN to loading.
module prog_mem_loader #(
  parameter int          AW   = 10,
  parameter logic [15:0] FILL = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
`ifdef PROG_MEM_RELOAD_EN
  input  logic            reload,
`endif
  prog_mem_loader_if.slave bus,
  output logic            run,
  output logic [AW:0]     words_loaded,
  output logic            err
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wptr;
  logic [7:0]    hi_byte;
  logic [15:0]   mem [DEPTH];
  logic          accept;
  logic          we;
  logic [15:0]   wdata;
  logic          set_err;
  logic          restart;
  logic          reload_req;
  logic          in_range;

`ifdef PROG_MEM_RELOAD_EN
  assign reload_req = reload;
`else
  assign reload_req = 1'b0;
`endif

  assign bus.load_ready = (state != RUN);
  assign accept         = bus.load_valid & bus.load_ready;
  assign in_range       = (bus.address[15:AW] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD_HI;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    wdata     = 16'h0000;
    set_err   = 1'b0;
    restart   = 1'b0;
    unique case (state)
      LOAD_HI: begin
        if (accept) begin
          // A lone trailing byte still forms a word, opcode in the high half.
          if (bus.load_last) begin
            we        = 1'b1;
            wdata     = {bus.load_data, 8'h00};
            state_nxt = RUN;
          end else begin
            state_nxt = LOAD_LO;
          end
        end
      end
      LOAD_LO: begin
        if (accept) begin
          we    = 1'b1;
          wdata = {hi_byte, bus.load_data};
          if (bus.load_last) begin
            state_nxt = RUN;
          end else if (&wptr) begin
            state_nxt = RUN;
            set_err   = 1'b1;
          end else begin
            state_nxt = LOAD_HI;
          end
        end
      end
      RUN: begin
        if (reload_req) begin
          state_nxt = LOAD_HI;
          restart   = 1'b1;
        end
      end
      default: state_nxt = LOAD_HI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      words_loaded <= '0;
      hi_byte      <= 8'h00;
      err          <= 1'b0;
      run          <= 1'b0;
    end else begin
      run <= (state_nxt == RUN);
      if (restart) begin
        wptr         <= '0;
        words_loaded <= '0;
        err          <= 1'b0;
      end else begin
        if (we) begin
          wptr         <= wptr + AW'(1);
          words_loaded <= words_loaded + (AW+1)'(1);
        end
        if (set_err) err <= 1'b1;
      end
      if (state == LOAD_HI && accept) hi_byte <= bus.load_data;
    end
  end

  // Storage is deliberately left out of reset so a restart keeps old contents.
  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.data_out <= FILL;
    else if (state == RUN && !reload_req)
      bus.data_out <= in_range ? mem[bus.address[AW-1:0]] : FILL;
    else
      bus.data_out <= FILL;
  end
endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: two instances (AW=10, AW=2) share one stimulus stream,
// each checked every cycle against a byte-count reference model.
module tb_prog_mem_loader;
  localparam logic [15:0] FILL = 16'hF00F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic        reload = 1'b0;
  logic [7:0]  load_data = 8'h00;
  logic [15:0] address = 16'h0000;

  int total = 0;
  int bad   = 0;

  logic        ready_v [2];
  logic        run_v   [2];
  logic        err_v   [2];
  logic [15:0] dout_v  [2];
  logic [10:0] wl_v    [2];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int AWI   = (g == 0) ? 10 : 2;
    localparam int DEPTH = 1 << AWI;

    prog_mem_loader_if bus();
    logic           run_o;
    logic           err_o;
    logic [AWI:0]   wl_o;

    assign bus.load_valid = load_valid;
    assign bus.load_data  = load_data;
    assign bus.load_last  = load_last;
    assign bus.address    = address;

    prog_mem_loader #(.AW(AWI), .FILL(FILL)) dut (
      .clk          (clk),
      .rst          (rst),
`ifdef PROG_MEM_RELOAD_EN
      .reload       (reload),
`endif
      .bus          (bus),
      .run          (run_o),
      .words_loaded (wl_o),
      .err          (err_o)
    );

    assign ready_v[g] = bus.load_ready;
    assign run_v[g]   = run_o;
    assign err_v[g]   = err_o;
    assign dout_v[g]  = bus.data_out;
    assign wl_v[g]    = 11'(wl_o);

    // Reference: count accepted bytes; byte n goes to word (n-1)/2, odd-numbered bytes are high.
    logic [15:0] mm [DEPTH];
    bit          known [DEPTH];
    int          nb = 0;
    bit          m_run = 0;
    bit          m_err = 0;
    logic [15:0] m_dout = FILL;
    bit          m_dk = 1;
    logic [7:0]  hb = 8'h00;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        nb = 0; m_run = 0; m_err = 0; m_dout = FILL; m_dk = 1;
      end else begin
        if (m_run && !reload) begin
          if ((int'(address) >> AWI) != 0) begin
            m_dout = FILL; m_dk = 1;
          end else begin
            m_dout = mm[int'(address) % DEPTH];
            m_dk   = known[int'(address) % DEPTH];
          end
        end else begin
          m_dout = FILL; m_dk = 1;
        end
        if (m_run && reload) begin
          m_run = 0; nb = 0; m_err = 0;
        end else if (!m_run && load_valid) begin
          nb++;
          if (nb % 2 == 1) begin
            hb = load_data;
            if (load_last) begin
              mm[nb/2] = {load_data, 8'h00}; known[nb/2] = 1; m_run = 1;
            end
          end else begin
            mm[nb/2-1] = {hb, load_data}; known[nb/2-1] = 1;
            if (load_last) m_run = 1;
            else if (nb == 2*DEPTH) begin m_run = 1; m_err = 1; end
          end
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("ready[%0d]", g), 32'(bus.load_ready), 32'(!m_run));
      chk($sformatf("run[%0d]", g), 32'(run_o), 32'(m_run));
      chk($sformatf("err[%0d]", g), 32'(err_o), 32'(m_err));
      chk($sformatf("words_loaded[%0d]", g), 32'(wl_o), m_run ? 32'((nb+1)/2) : 32'(nb/2));
      if (m_dk) chk($sformatf("data_out[%0d]", g), 32'(bus.data_out), 32'(m_dout));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; reload = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    load_valid = 1'b1; load_data = b; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic read_chk(input int inst, input logic [15:0] a, input logic [15:0] exp, input string nm);
    address = a;
    tick();
    chk(nm, 32'(dout_v[inst]), 32'(exp));
  endtask

  initial begin
    logic [7:0] img [6];
    img = '{8'h80, 8'h05, 8'h80, 8'h07, 8'h00, 8'h02};

    tick();
    do_reset();
    chk("rst_ready", 32'(ready_v[0]), 1);
    chk("rst_run", 32'(run_v[0]), 0);
    chk("rst_wl", 32'(wl_v[0]), 0);
    chk("rst_dout", 32'(dout_v[0]), 32'(FILL));

    // Six-byte image.
    for (int i = 0; i < 6; i++) send(img[i], i == 5);
    chk("img_run", 32'(run_v[0]), 1);
    chk("img_wl", 32'(wl_v[0]), 3);
    read_chk(0, 16'd0, 16'h8005, "img_w0");
    read_chk(0, 16'd1, 16'h8007, "img_w1");
    read_chk(1, 16'd2, 16'h0002, "img_w2_aw2");

    // Odd byte count.
    do_reset();
    send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 1);
    chk("odd_run", 32'(run_v[0]), 1);
    chk("odd_wl", 32'(wl_v[0]), 2);
    read_chk(0, 16'd1, 16'hC300, "odd_w1");

    // AW=2 overflow: ten bytes, no load_last.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(8'h10 + 8'(i), 0);
      if (i == 7) begin
        chk("full_run", 32'(run_v[1]), 1);
        chk("full_err", 32'(err_v[1]), 1);
        chk("full_ready", 32'(ready_v[1]), 0);
        chk("full_wl", 32'(wl_v[1]), 4);
      end
    end
    chk("full_aw10_ready", 32'(ready_v[0]), 1);
    read_chk(1, 16'd0, 16'h1011, "full_w0");
    read_chk(1, 16'd3, 16'h1617, "full_w3");

    // Reset mid-load, then a fresh one-word image.
    do_reset();
    send(8'h55, 0); send(8'h66, 0); send(8'h77, 0);
    do_reset();
    send(8'h12, 0); send(8'h34, 1);
    chk("rl_wl", 32'(wl_v[0]), 1);
    chk("rl_err", 32'(err_v[0]), 0);
    read_chk(0, 16'd0, 16'h1234, "rl_w0");
    read_chk(0, 16'h0400, FILL, "oor_fill");
    read_chk(0, 16'd0, 16'h1234, "oor_back");

`ifdef PROG_MEM_RELOAD_EN
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("reload_run", 32'(run_v[0]), 0);
    chk("reload_ready", 32'(ready_v[0]), 1);
    chk("reload_dout", 32'(dout_v[0]), 32'(FILL));
    send(8'h56, 0); send(8'h78, 1);
    read_chk(0, 16'd0, 16'h5678, "reload_w0");
`endif

    // Randomized loads with idle gaps and stray load_last, then random fetches.
    for (int it = 0; it < 40; it++) begin
      int  len;
      bit  use_last;
      len      = $urandom_range(1, 24);
      use_last = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) do_reset();
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 3) == 0) begin
          load_valid = 1'b0;
          load_last  = 1'($urandom_range(0, 1));
          load_data  = 8'($urandom);
          address    = 16'($urandom_range(0, 7));
          tick();
        end
        send(8'($urandom), use_last && (i == len - 1));
      end
      for (int c = 0; c < 16; c++) begin
        case ($urandom_range(0, 3))
          0:       address = 16'h0400;
          1:       address = 16'($urandom) & 16'h7fff;
          default: address = 16'($urandom_range(0, 7));
        endcase
`ifdef PROG_MEM_RELOAD_EN
        reload = ($urandom_range(0, 15) == 0);
`endif
        tick();
      end
      reload = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
